// File: rtl/vx_alu_dispatch_arb.sv
// Round-robin arbiter that shares one ALU request channel among NUM_REQS issue slices.
// The granted payload lands in a 2-entry elastic buffer, so every ALU-side output comes from a register.
module vx_alu_dispatch_arb #(
    parameter int NUM_REQS = 4,
    parameter int DATAW    = 256,
    parameter int IDXW     = $clog2(NUM_REQS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQS-1:0]          req_valid,
    input  logic [NUM_REQS*DATAW-1:0]    req_data,
    output logic [NUM_REQS-1:0]          req_ready,
    output logic                         alu_valid,
    output logic [DATAW-1:0]             alu_data,
    output logic [IDXW-1:0]              alu_src,
    input  logic                         alu_ready,
    output logic                         busy
);

    logic [IDXW-1:0]  rr_ptr;
    logic [IDXW-1:0]  grant;
    logic             has_grant;
    logic [1:0]       count;
    logic             wr_ptr;
    logic             rd_ptr;
    logic             full;
    logic             push;
    logic             pop;
    logic [DATAW-1:0] buf_data [2];
    logic [IDXW-1:0]  buf_src  [2];

    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        has_grant = 1'b0;
        for (int k = 0; k < NUM_REQS; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQS) begin
                idx = idx - NUM_REQS;
            end
            if (!has_grant && req_valid[idx]) begin
                has_grant = 1'b1;
                grant     = IDXW'(idx);
            end
        end
    end

    // Ready is deliberately blind to alu_ready: a full buffer stalls issue even in a pop cycle,
    // which keeps the ALU handshake off the issue-side timing path.
    assign full      = (count == 2'd2);
    assign push      = has_grant & ~full & ~reset;
    assign req_ready = push ? (NUM_REQS'(1) << grant) : '0;
    assign pop       = alu_valid & alu_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr      <= '0;
            count       <= 2'd0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_src[0]  <= '0;
            buf_src[1]  <= '0;
        end else begin
            if (push) begin
                buf_data[wr_ptr] <= req_data[grant*DATAW +: DATAW];
                buf_src[wr_ptr]  <= grant;
                wr_ptr           <= ~wr_ptr;
                rr_ptr           <= (grant == IDXW'(NUM_REQS-1)) ? '0 : grant + 1'b1;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign alu_valid = (count != 2'd0);
    assign alu_data  = buf_data[rd_ptr];
    assign alu_src   = buf_src[rd_ptr];
    assign busy      = (count != 2'd0) | (|req_valid);

    // Requester-side handshake: a pending request must hold valid and payload until accepted.
    for (genvar i = 0; i < NUM_REQS; i++) begin : g_req_chk
        a_hold : assert property (@(posedge clk) disable iff (reset)
            (req_valid[i] && !req_ready[i]) |=>
            (req_valid[i] && $stable(req_data[i*DATAW +: DATAW])));
    end

    a_onehot : assert property (@(posedge clk) disable iff (reset) $onehot0(req_ready));
    a_count  : assert property (@(posedge clk) disable iff (reset) count <= 2'd2);

endmodule
